// File: rtl/fb_paint_writer_pkg.sv
// Shared constants, FSM state encoding and address helper for the framebuffer paint writer.
// The CLR state only exists when FB_CLEAR_EN is defined.
package fb_paint_writer_pkg;

  localparam int NUM_COLS   = 64;
  localparam int NUM_ROWS   = 64;
  localparam int BIT_DEPTH  = 4;
  localparam int PIX_W      = 3 * BIT_DEPTH;
  localparam int X_W        = $clog2(NUM_COLS);
  localparam int Y_W        = $clog2(NUM_ROWS);
  localparam int ROW_W      = Y_W - 1;
  localparam int ADDR_W     = 11;
  localparam int WORD_W     = 24;
  localparam int NUM_WORDS  = 1 << ADDR_W;

  localparam logic [PIX_W-1:0] BG_COLOR_DEF = 12'h000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3
`ifdef FB_CLEAR_EN
    ,
    ST_CLR  = 3'd4
`endif
  } state_t;

  // Top and bottom panel halves share one word, so the row MSB only selects the half.
  function automatic logic [ADDR_W-1:0] pixAddr(input logic [Y_W-1:0] y, input logic [X_W-1:0] x);
    return {y[ROW_W-1:0], x};
  endfunction

endpackage

// File: rtl/fb_paint_writer_if.sv
// Paint request, clear request and framebuffer write-port signals of the paint writer.
// slave = the writer itself, master = whoever drives paint requests and serves the memory port.
interface fb_paint_writer_if;
  import fb_paint_writer_pkg::*;

  logic              px_valid;
  logic              px_ready;
  logic [X_W-1:0]    px_x;
  logic [Y_W-1:0]    px_y;
  logic [PIX_W-1:0]  px_color;
  logic              clr_req;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_we;
  logic [WORD_W-1:0] mem_wdata;

  modport slave (
    input  px_valid, px_x, px_y, px_color, clr_req, mem_rdata,
    output px_ready, busy, mem_addr, mem_rd, mem_we, mem_wdata
  );

  modport master (
    output px_valid, px_x, px_y, px_color, clr_req, mem_rdata,
    input  px_ready, busy, mem_addr, mem_rd, mem_we, mem_wdata
  );

endinterface

// File: rtl/fb_paint_writer_px_merge.sv
// Combinational pixel merge: drops a new colour into one half of a framebuffer word,
// keeping the other half-pixel bit-exact.
module fb_px_merge
  import fb_paint_writer_pkg::*;
(
  input  logic [WORD_W-1:0] i_old,
  input  logic [PIX_W-1:0]  i_color,
  input  logic              i_low_half,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    if (i_low_half) begin
      o_word = {i_old[WORD_W-1:PIX_W], i_color};
    end else begin
      o_word = {i_color, i_old[PIX_W-1:0]};
    end
  end

endmodule

// File: rtl/fb_paint_writer.sv
// Paint writer: read-modify-write of single pixels into the panel framebuffer, plus an
// optional full-screen clear built only when FB_CLEAR_EN is defined.
module fb_paint_writer
  import fb_paint_writer_pkg::*;
`ifdef FB_CLEAR_EN
#(
  parameter logic [PIX_W-1:0] BG_COLOR = BG_COLOR_DEF
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  fb_paint_writer_if.slave bus
);

  state_t            r_state, w_next_state;
  logic              r_px_ready, w_px_ready;
  logic              r_busy, w_busy;
  logic              r_mem_rd, w_mem_rd;
  logic              r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata, w_mem_wdata;
  logic [PIX_W-1:0]  r_color, w_color;
  logic              r_low_half, w_low_half;
  logic [WORD_W-1:0] w_merged;
  logic              w_px_ready_out;
  logic              w_accept;
`ifdef FB_CLEAR_EN
  logic              r_clr_pend, w_clr_pend;
  logic              w_clr_now;
`endif

  fb_px_merge u_merge (
    .i_old      (bus.mem_rdata),
    .i_color    (r_color),
    .i_low_half (r_low_half),
    .o_word     (w_merged)
  );

  // A clear pulse arriving in an idle cycle wins over a paint request in that same cycle.
`ifdef FB_CLEAR_EN
  assign w_clr_now      = bus.clr_req | r_clr_pend;
  assign w_px_ready_out = r_px_ready & ~bus.clr_req;
`else
  assign w_px_ready_out = r_px_ready;
`endif
  assign w_accept       = bus.px_valid & w_px_ready_out;

  assign bus.px_ready  = w_px_ready_out;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wdata = r_mem_wdata;

  always_comb begin
    w_next_state = r_state;
    w_mem_rd     = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_color      = r_color;
    w_low_half   = r_low_half;
    w_px_ready   = 1'b0;
    w_busy       = 1'b0;
`ifdef FB_CLEAR_EN
    w_clr_pend   = r_clr_pend;
`endif

    case (r_state)
      ST_IDLE: begin
`ifdef FB_CLEAR_EN
        if (w_clr_now) begin
          w_next_state = ST_CLR;
          w_clr_pend   = 1'b0;
          w_mem_addr   = '0;
          w_mem_we     = 1'b1;
          w_mem_wdata  = {BG_COLOR, BG_COLOR};
        end else
`endif
        if (w_accept) begin
          w_next_state = ST_RD;
          w_mem_addr   = pixAddr(bus.px_y, bus.px_x);
          w_mem_rd     = 1'b1;
          w_color      = bus.px_color;
          w_low_half   = bus.px_y[Y_W-1];
        end
      end
      ST_RD: begin
        w_next_state = ST_WAIT;
      end
      // Read data is on the bus during this cycle; the merged word is registered directly.
      ST_WAIT: begin
        w_next_state = ST_WR;
        w_mem_we     = 1'b1;
        w_mem_wdata  = w_merged;
      end
      ST_WR: begin
        w_next_state = ST_IDLE;
      end
`ifdef FB_CLEAR_EN
      ST_CLR: begin
        if (r_mem_addr == ADDR_W'(NUM_WORDS - 1)) begin
          w_next_state = ST_IDLE;
        end else begin
          w_mem_we   = 1'b1;
          w_mem_addr = r_mem_addr + ADDR_W'(1);
        end
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

`ifdef FB_CLEAR_EN
    if ((r_state != ST_IDLE) && bus.clr_req) begin
      w_clr_pend = 1'b1;
    end
    w_px_ready = (w_next_state == ST_IDLE) && !w_clr_pend;
`else
    w_px_ready = (w_next_state == ST_IDLE);
`endif
    w_busy = (w_next_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_px_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_color     <= '0;
      r_low_half  <= 1'b0;
`ifdef FB_CLEAR_EN
      r_clr_pend  <= 1'b0;
`endif
    end else begin
      r_state     <= w_next_state;
      r_px_ready  <= w_px_ready;
      r_busy      <= w_busy;
      r_mem_rd    <= w_mem_rd;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_color     <= w_color;
      r_low_half  <= w_low_half;
`ifdef FB_CLEAR_EN
      r_clr_pend  <= w_clr_pend;
`endif
    end
  end

endmodule
